// File: rtl/frame_buffer_if.sv
// frame_buffer_if: pixel read/write ports, raster dump stream and error flag of the frame buffer.
interface frame_buffer_if #(
  parameter int X_MAX = 200,
  parameter int Y_MAX = 200,
  parameter int PIXEL_DEPTH = 8
);
  localparam int XW = $clog2(X_MAX) + 1;
  localparam int YW = $clog2(Y_MAX) + 1;
  logic [XW-1:0] x_addr_rd;
  logic [YW-1:0] y_addr_rd;
  logic ren;
  logic [PIXEL_DEPTH-1:0] rdat;
  logic rvalid;
  logic [XW-1:0] x_addr_wr;
  logic [YW-1:0] y_addr_wr;
  logic wen;
  logic [PIXEL_DEPTH-1:0] wdat;
  logic [XW-2:0] max_x;
  logic [YW-2:0] max_y;
  logic dump_start;
  logic [PIXEL_DEPTH-1:0] dump_data;
  logic dump_valid;
  logic dump_ready;
  logic dump_last;
  logic dump_busy;
  logic dump_done;
  logic addr_err;
  logic clr_err;
  modport master (
    output x_addr_rd, y_addr_rd, ren, x_addr_wr, y_addr_wr, wen, wdat,
           max_x, max_y, dump_start, dump_ready, clr_err,
    input  rdat, rvalid, dump_data, dump_valid, dump_last, dump_busy, dump_done, addr_err
  );
  modport slave (
    input  x_addr_rd, y_addr_rd, ren, x_addr_wr, y_addr_wr, wen, wdat,
           max_x, max_y, dump_start, dump_ready, clr_err,
    output rdat, rvalid, dump_data, dump_valid, dump_last, dump_busy, dump_done, addr_err
  );
endinterface

// File: rtl/frame_buffer.sv
// frame_buffer: x/y addressed pixel store with range checking and a raster-order valid/ready drain.
module frame_buffer #(
  parameter int X_MAX = 200,
  parameter int Y_MAX = 200,
  parameter int PIXEL_DEPTH = 8
) (
  input logic clk,
  input logic n_rst,
  frame_buffer_if.slave b
);
  localparam int XC = $clog2(X_MAX);
  localparam int YC = $clog2(Y_MAX);
  localparam int AW = $clog2(X_MAX * Y_MAX);
  localparam logic [XC:0] XL = (XC+1)'(X_MAX);
  localparam logic [YC:0] YL = (YC+1)'(Y_MAX);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t state, state_n;
  logic [PIXEL_DEPTH-1:0] mem [X_MAX*Y_MAX];
  logic [XC-1:0] dx, mx;
  logic [YC-1:0] dy, my;
  logic rd_ok, wr_ok, d_ok, rd_acc, hs, at_end, start;
  logic [AW-1:0] ridx, widx, didx;
  assign rd_ok = b.x_addr_rd < XL && b.y_addr_rd < YL;
  assign wr_ok = b.x_addr_wr < XL && b.y_addr_wr < YL;
  assign d_ok = {1'b0, dx} < XL && {1'b0, dy} < YL;
  assign ridx = AW'(b.y_addr_rd * X_MAX + b.x_addr_rd);
  assign widx = AW'(b.y_addr_wr * X_MAX + b.x_addr_wr);
  assign didx = AW'(dy * X_MAX + dx);
  assign rd_acc = b.ren && state == IDLE;
  assign start = b.dump_start && state == IDLE;
  assign hs = state == HOLD && b.dump_ready;
  assign at_end = dx == mx && dy == my;
  always_comb begin
    state_n = state;
    b.dump_valid = state == HOLD;
    b.dump_last = state == HOLD && at_end;
    b.dump_busy = state != IDLE;
    if (start) state_n = FETCH;
    if (state == FETCH) state_n = HOLD;
    if (hs) state_n = at_end ? IDLE : FETCH;
  end
  // storage is deliberately outside the reset domain so a mid-dump reset keeps the frame
  always_ff @(posedge clk)
    if (b.wen && wr_ok) mem[widx] <= b.wdat;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      dx <= '0;
      dy <= '0;
      mx <= '0;
      my <= '0;
      b.rdat <= '0;
      b.rvalid <= 1'b0;
      b.dump_data <= '0;
      b.dump_done <= 1'b0;
      b.addr_err <= 1'b0;
    end else begin
      state <= state_n;
      b.dump_done <= hs && at_end;
      b.rvalid <= rd_acc;
      if (rd_acc) b.rdat <= rd_ok ? mem[ridx] : '0;
      b.addr_err <= (b.wen && !wr_ok) || (rd_acc && !rd_ok) || (b.addr_err && !b.clr_err);
      if (start) begin
        dx <= '0;
        dy <= '0;
        mx <= b.max_x;
        my <= b.max_y;
      end
      if (state == FETCH) b.dump_data <= d_ok ? mem[didx] : '0;
      if (hs && !at_end) begin
        dx <= dx == mx ? '0 : dx + 1'b1;
        dy <= dx == mx ? dy + 1'b1 : dy;
      end
    end
  end
endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: directed checks of read/write, range errors, raster dump and mid-dump reset.
module tb_frame_buffer;
  logic clk, n_rst;
  int checks = 0, errors = 0;
  frame_buffer_if b ();
  frame_buffer dut (.clk(clk), .n_rst(n_rst), .b(b));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic chk_outs_zero(input string tag);
    chk({tag, "_rdat"}, b.rdat, 0);
    chk({tag, "_ctl"}, {b.rvalid, b.dump_valid, b.dump_last, b.dump_busy, b.dump_done, b.addr_err}, 0);
    chk({tag, "_ddata"}, b.dump_data, 0);
  endtask
  task automatic wr(input int x, input int y, input int d);
    b.wen = 1; b.x_addr_wr = 9'(x); b.y_addr_wr = 9'(y); b.wdat = 8'(d);
    tick();
    b.wen = 0;
  endtask
  task automatic rd(input int x, input int y);
    b.ren = 1; b.x_addr_rd = 9'(x); b.y_addr_rd = 9'(y);
    tick();
    b.ren = 0;
  endtask
  task automatic run_dump(input bit rnd, input int stop_at);
    int beats = 0, dones = 0, cyc = 0;
    bit ps = 0, pb = 0, served;
    logic [7:0] pd = 0;
    served = b.ren;
    b.max_x = 3; b.max_y = 2; b.dump_start = 1;
    tick();
    b.dump_start = 0; b.max_x = 0; b.max_y = 0;
    chk("busy_rise", b.dump_busy, 1);
    chk("valid_first", b.dump_valid, 0);
    if (served) chk("ren_with_start", {b.rvalid, b.rdat}, 9'h123);
    while (cyc < 200 && dones == 0 && beats < stop_at) begin
      b.dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ps) chk("stall_hold", b.dump_data, pd);
      if (pb) chk("ren_ignored", b.rvalid, 0);
      if (b.dump_valid && b.dump_ready) begin
        chk($sformatf("beat%0d", beats), b.dump_data, (beats / 4) * 16 + beats % 4);
        chk($sformatf("last%0d", beats), b.dump_last, beats == 11);
        beats++;
      end
      ps = b.dump_valid && !b.dump_ready;
      pd = b.dump_data;
      pb = b.dump_busy;
      tick();
      if (b.dump_done) begin
        dones++;
        chk("done_busy", b.dump_busy, 0);
      end
      cyc++;
    end
    if (stop_at == 12) begin
      chk("beats", beats, 12);
      chk("done_seen", dones, 1);
      tick();
      chk("done_pulse", b.dump_done, 0);
    end else chk("partial_beats", beats, stop_at);
  endtask
  initial begin
    n_rst = 0;
    b.x_addr_rd = 0; b.y_addr_rd = 0; b.ren = 0;
    b.x_addr_wr = 0; b.y_addr_wr = 0; b.wen = 0; b.wdat = 0;
    b.max_x = 0; b.max_y = 0; b.dump_start = 0; b.dump_ready = 0; b.clr_err = 0;
    tick(); tick();
    chk_outs_zero("reset");
    n_rst = 1;
    tick();
    wr(3, 2, 'hA5);
    rd(3, 2);
    chk("rd_valid", b.rvalid, 1);
    chk("rd_data", b.rdat, 'hA5);
    tick();
    chk("rd_single", b.rvalid, 0);
    chk("rd_hold", b.rdat, 'hA5);
    wr(0, 0, 'h11);
    b.ren = 1; b.x_addr_rd = 0; b.y_addr_rd = 0;
    wr(0, 0, 'h22);
    b.ren = 0;
    chk("rbw_old", b.rdat, 'h11);
    rd(0, 0);
    chk("rbw_new", b.rdat, 'h22);
    wr(0, 1, 'h77);
    chk("err_clean", b.addr_err, 0);
    wr(200, 0, 'hFF);
    chk("wr_oor_err", b.addr_err, 1);
    rd(0, 1);
    chk("wr_oor_dropped", b.rdat, 'h77);
    chk("err_sticky", b.addr_err, 1);
    b.clr_err = 1;
    tick();
    b.clr_err = 0;
    chk("err_clr", b.addr_err, 0);
    b.clr_err = 1;
    rd(0, 200);
    b.clr_err = 0;
    chk("err_set_wins", b.addr_err, 1);
    chk("rd_oor", {b.rvalid, b.rdat}, 9'h100);
    b.clr_err = 1;
    tick();
    b.clr_err = 0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) wr(x, y, y * 16 + x);
    b.ren = 1; b.x_addr_rd = 3; b.y_addr_rd = 2;
    run_dump(0, 12);
    b.ren = 0;
    tick();
    chk("dump_no_err", b.addr_err, 0);
    run_dump(1, 12);
    run_dump(0, 5);
    #2 n_rst = 0;
    #1;
    chk_outs_zero("mid_reset");
    tick();
    n_rst = 1;
    tick();
    run_dump(0, 12);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
